// File: rtl/mux_arb_nto1_if.sv
// Handshake bundle for mux_arb_nto1: N_CH producer channels in, one consumer stream out.
// master = producers/consumer side, slave = the mux itself.
interface mux_arb_nto1_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_CH)
);
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_valid;
  logic [N_CH-1:0]        in_last;
  logic [N_CH-1:0]        in_ready;
  logic                   mode;
  logic [SEL_W-1:0]       sel;
  logic [DATA_W-1:0]      out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [SEL_W-1:0]       out_ch;

  modport master (
    output in_data, in_valid, in_last, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, in_last, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/mux_arb_nto1.sv
// N-channel registered stream mux: fixed select or round-robin, one-entry output register.
// Optional packet lock (stay on a channel until in_last) enabled by defining MUX_LOCK_EN.
module mux_arb_nto1 #(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(N_CH)
)(
  input logic           clk,
  input logic           rst_n,
  mux_arb_nto1_if.slave bus
);
  logic [SEL_W-1:0]  ptr, rr_gnt, rr_idx, gnt, out_ch_q;
  logic              rr_found, fix_v, gnt_v, space, xfer_in, gnt_last;
  logic [DATA_W-1:0] gnt_data, out_data_q;
  logic              out_valid_q;

  assign space   = !out_valid_q || bus.out_ready;
  assign xfer_in = gnt_v && space;

  // Round-robin: first valid channel scanning from ptr with wrap.
  always_comb begin
    rr_gnt   = ptr;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      rr_idx = SEL_W'((int'(ptr) + k) % N_CH);
      if (!rr_found && bus.in_valid[rr_idx]) begin
        rr_gnt   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  // Decoded by loop so out-of-range sel simply matches nothing.
  always_comb begin
    fix_v = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (bus.sel == SEL_W'(i)) fix_v = bus.in_valid[i];
  end

`ifdef MUX_LOCK_EN
  logic             lock;
  logic [SEL_W-1:0] lock_ch;

  always_comb begin
    gnt   = bus.mode ? rr_gnt : bus.sel;
    gnt_v = bus.mode ? |bus.in_valid : fix_v;
    if (lock) begin
      gnt   = lock_ch;
      gnt_v = bus.in_valid[lock_ch];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock    <= 1'b0;
      lock_ch <= '0;
    end else if (xfer_in) begin
      lock    <= !gnt_last;
      lock_ch <= gnt;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^bus.in_last ^ gnt_last;

  always_comb begin
    gnt   = bus.mode ? rr_gnt : bus.sel;
    gnt_v = bus.mode ? |bus.in_valid : fix_v;
  end
`endif

  always_comb begin
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (gnt == SEL_W'(i)) begin
        gnt_data = bus.in_data[i*DATA_W +: DATA_W];
        gnt_last = bus.in_last[i];
      end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_rdy
    assign bus.in_ready[i] = xfer_in && (gnt == SEL_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr         <= '0;
    end else begin
      if (xfer_in) begin
        out_valid_q <= 1'b1;
        out_data_q  <= gnt_data;
        out_ch_q    <= gnt;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (xfer_in && bus.mode)
        ptr <= (gnt == SEL_W'(N_CH-1)) ? '0 : gnt + 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule
